// File: rtl/sbd_fifo.sv
// rtl/sbd_fifo.sv - dual-port in / dual-port out scoreboard FIFO
package sbd_fifo_pkg;

  // One scoreboard entry: one-hot pipeline lane plus the instruction pc.
  typedef struct packed {
    logic [3:0]  pl;
    logic [31:0] pc;
  } sbd_fifo_t;

endpackage

module sbd_fifo
  import sbd_fifo_pkg::*;
#(
  parameter int Depth     = 8,
  parameter bit CHERIoTEn = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [1:0]               wr_valid_i,
  input  sbd_fifo_t                wdata0_i,
  input  sbd_fifo_t                wdata1_i,
  output logic [1:0]               wr_rdy_o,
  output logic [1:0]               rd_valid_o,
  output sbd_fifo_t                rdata0_o,
  output sbd_fifo_t                rdata1_o,
  input  logic [1:0]               rd_rdy_i,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  sbd_fifo_t     mem [Depth];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_p1;
  logic [PW-1:0] rptr_p1;
  logic [PW-1:0] count;
  logic [1:0]    nwr;
  logic [1:0]    nrd;

  // Kept only so the parameter list matches the rest of the package.
  logic unused_cheriot;
  assign unused_cheriot = CHERIoTEn;

  // The extra pointer MSB separates full from empty; difference wraps naturally.
  assign count   = wptr - rptr;
  assign count_o = count;
  assign wptr_p1 = wptr + PW'(1);
  assign rptr_p1 = rptr + PW'(1);

  // Space and data-available flags come from registered pointers only.
  always_comb begin
    wr_rdy_o[0]   = (count <= PW'(Depth - 1));
    wr_rdy_o[1]   = (count <= PW'(Depth - 2));
    rd_valid_o[0] = (count >= PW'(1));
    rd_valid_o[1] = (count >= PW'(2));
    rdata0_o      = mem[rptr[AW-1:0]];
    rdata1_o      = mem[rptr_p1[AW-1:0]];
  end

  // Accepted enqueue/dequeue counts; the second slot needs the first.
  always_comb begin
    nwr = 2'd0;
    nrd = 2'd0;
    if (!flush_i && wr_valid_i[0] && wr_rdy_o[0]) begin
      nwr = (wr_valid_i[1] && wr_rdy_o[1]) ? 2'd2 : 2'd1;
    end
    if (!flush_i && rd_rdy_i[0] && rd_valid_o[0]) begin
      nrd = (rd_rdy_i[1] && rd_valid_o[1]) ? 2'd2 : 2'd1;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (nwr != 2'd0) begin
      mem[wptr[AW-1:0]] <= wdata0_i;
    end
    if (nwr == 2'd2) begin
      mem[wptr_p1[AW-1:0]] <= wdata1_i;
    end
  end

  // Pointer update: reset and flush both empty the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(nwr);
      rptr <= rptr + PW'(nrd);
    end
  end

endmodule

// File: tb/tb_sbd_fifo.sv
// tb/tb_sbd_fifo.sv - randomized self-checking bench for sbd_fifo
module tb_sbd_fifo;
  import sbd_fifo_pkg::*;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] wr_valid = 2'b00;
  logic [1:0] rd_rdy = 2'b00;
  sbd_fifo_t  wdata0 = '0;
  sbd_fifo_t  wdata1 = '0;
  logic [1:0] wr_rdy;
  logic [1:0] rd_valid;
  sbd_fifo_t  rdata0;
  sbd_fifo_t  rdata1;
  logic [3:0] count;

  int checks = 0;
  int passed = 0;

  sbd_fifo_t q[$];

  sbd_fifo #(.Depth(D), .CHERIoTEn(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .wr_valid_i(wr_valid), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .wr_rdy_o(wr_rdy), .rd_valid_o(rd_valid),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .rd_rdy_i(rd_rdy), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic sbd_fifo_t rnd_entry();
    sbd_fifo_t e;
    e.pl = 4'b0001 << $urandom_range(0, 3);
    e.pc = $urandom & 32'hffff_fffc;
    return e;
  endfunction

  function automatic sbd_fifo_t mk(input logic [31:0] pc);
    sbd_fifo_t e;
    e.pl = 4'b0001;
    e.pc = pc;
    return e;
  endfunction

  // Compare all visible outputs against the queue model.
  task automatic check_outputs(input string tag);
    int n = q.size();
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".rd_valid"}, 64'(rd_valid), {62'd0, n >= 2, n >= 1});
    chk({tag, ".wr_rdy"}, 64'(wr_rdy), {62'd0, n <= D - 2, n <= D - 1});
    if (n >= 1) chk({tag, ".rdata0"}, 64'(rdata0), 64'(q[0]));
    if (n >= 2) chk({tag, ".rdata1"}, 64'(rdata1), 64'(q[1]));
  endtask

  // Called at a negedge: check, drive one cycle, update the model, return at next negedge.
  task automatic step(input string tag, input logic [1:0] wv, input logic [1:0] rr,
                      input logic fl, input sbd_fifo_t d0, input sbd_fifo_t d1);
    int n = q.size();
    int nw = 0;
    int nr = 0;
    check_outputs(tag);
    wr_valid = wv;
    rd_rdy = rr;
    flush = fl;
    wdata0 = d0;
    wdata1 = d1;
    if (!fl && wv[0] && (D - n) >= 1) nw = (wv[1] && (D - n) >= 2) ? 2 : 1;
    if (!fl && rr[0] && n >= 1) nr = (rr[1] && n >= 2) ? 2 : 1;
    if (fl) q.delete();
    else begin
      for (int i = 0; i < nr; i++) void'(q.pop_front());
      if (nw >= 1) q.push_back(d0);
      if (nw == 2) q.push_back(d1);
    end
    @(posedge clk);
    @(negedge clk);
    wr_valid = 2'b00;
    rd_rdy = 2'b00;
    flush = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Dual write right after reset.
    step("dual_wr", 2'b11, 2'b00, 1'b0, mk(32'h100), mk(32'h104));
    chk("dual_wr.pc0", 64'(rdata0.pc), 64'h100);
    chk("dual_wr.pc1", 64'(rdata1.pc), 64'h104);

    // Fill to 7, then a dual write accepts one, then full read with write blocked.
    for (int i = 0; i < 5; i++) step("fill", 2'b01, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    chk("fill7.wr_rdy", 64'(wr_rdy), 64'b01);
    step("full_wr", 2'b11, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    chk("full.count", 64'(count), 64'd8);
    chk("full.wr_rdy", 64'(wr_rdy), 64'b00);
    step("full_rw", 2'b11, 2'b11, 1'b0, rnd_entry(), rnd_entry());
    chk("full_rw.count", 64'(count), 64'd6);

    // Pointers to index 7, then a dual write/read that straddles the wrap.
    step("flush0", 2'b00, 2'b00, 1'b1, rnd_entry(), rnd_entry());
    for (int i = 0; i < 7; i++) step("walk", 2'b01, 2'b01, 1'b0, rnd_entry(), rnd_entry());
    step("walk_drain", 2'b00, 2'b01, 1'b0, rnd_entry(), rnd_entry());
    step("wrap_wr", 2'b11, 2'b00, 1'b0, mk(32'h700), mk(32'h800));
    chk("wrap.pc0", 64'(rdata0.pc), 64'h700);
    chk("wrap.pc1", 64'(rdata1.pc), 64'h800);
    step("wrap_rd", 2'b00, 2'b11, 1'b0, rnd_entry(), rnd_entry());
    step("post_wrap_wr", 2'b01, 2'b00, 1'b0, mk(32'h900), rnd_entry());
    chk("post_wrap.pc0", 64'(rdata0.pc), 64'h900);
    step("post_wrap_rd", 2'b00, 2'b01, 1'b0, rnd_entry(), rnd_entry());

    // Flush at count 3 drops same-cycle reads and writes.
    step("f3a", 2'b11, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    step("f3b", 2'b01, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    step("flush3", 2'b11, 2'b11, 1'b1, rnd_entry(), rnd_entry());
    chk("flush3.count", 64'(count), 64'd0);

    // rd_rdy=10 is ignored; rd_rdy=11 with a single entry takes just one.
    step("r2a", 2'b11, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    step("rd10", 2'b00, 2'b10, 1'b0, rnd_entry(), rnd_entry());
    chk("rd10.count", 64'(count), 64'd2);
    step("rd1", 2'b00, 2'b01, 1'b0, rnd_entry(), rnd_entry());
    step("rd11_one", 2'b00, 2'b11, 1'b0, rnd_entry(), rnd_entry());
    chk("rd11_one.count", 64'(count), 64'd0);
    step("wr10", 2'b10, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    chk("wr10.count", 64'(count), 64'd0);

    // Asynchronous reset at count 5 empties the queue before any edge.
    step("ar_a", 2'b11, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    step("ar_b", 2'b11, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    step("ar_c", 2'b01, 2'b00, 1'b0, rnd_entry(), rnd_entry());
    chk("ar.pre_count", 64'(count), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar.count", 64'(count), 64'd0);
    chk("ar.rd_valid", 64'(rd_valid), 64'b00);
    chk("ar.wr_rdy", 64'(wr_rdy), 64'b11);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] wv = 2'($urandom_range(0, 3));
      logic [1:0] rr = 2'($urandom_range(0, 3));
      logic       fl = ($urandom_range(0, 49) == 0);
      if (i % 100 < 40 && $urandom_range(0, 1) == 1) rr = 2'b00;
      step("rand", wv, rr, fl, rnd_entry(), rnd_entry());
    end
    check_outputs("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
